// File: rtl/banco_registros_sb.sv
// Register bank with combinational dual read, synchronous write and a per-register pending scoreboard.
// Optional write-through forwarding on the read ports: define BANCO_REGISTROS_SB_BYPASS_EN.
module banco_registros_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Write,
   input  logic [ADDR_W-1:0] WA,
   input  logic [DATA_W-1:0] WD,
   input  logic [ADDR_W-1:0] RR1,
   input  logic [ADDR_W-1:0] RR2,
   output logic [DATA_W-1:0] DR1,
   output logic [DATA_W-1:0] DR2,
   input  logic              Reserve,
   input  logic [ADDR_W-1:0] RA,
   output logic              Busy1,
   output logic              Busy2,
   output logic [ADDR_W:0]   PendCnt
);

   localparam int              DEPTH    = 2 ** ADDR_W;
   localparam logic            HAS_ZERO = (ZERO_REG != 0);
   localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   logic [DATA_W-1:0] regs_r [DEPTH];
   logic [DEPTH-1:0]  pend_r;
   logic [DEPTH-1:0]  pend_nxt_s;
   logic [ADDR_W:0]   cnt_r;
   logic [ADDR_W:0]   cnt_nxt_s;
   logic              wr_ok_s;
   logic              rsv_ok_s;
   logic              inc_s;
   logic              dec_s;

   // Qualify write and reserve requests against the hardwired zero register.
   always_comb begin
      wr_ok_s  = Write;
      rsv_ok_s = Reserve;
      if (HAS_ZERO && (WA == {ADDR_W{1'b0}})) begin
         wr_ok_s = 1'b0;
      end else begin
         wr_ok_s = Write;
      end
      if (HAS_ZERO && (RA == {ADDR_W{1'b0}})) begin
         rsv_ok_s = 1'b0;
      end else begin
         rsv_ok_s = Reserve;
      end
   end

   // Next pending vector and counter delta; a reserve on the written register wins over the clear.
   always_comb begin
      pend_nxt_s = pend_r;
      if (wr_ok_s) begin
         pend_nxt_s[WA] = 1'b0;
      end else begin
         pend_nxt_s[WA] = pend_r[WA];
      end
      if (rsv_ok_s) begin
         pend_nxt_s[RA] = 1'b1;
      end else begin
         pend_nxt_s[RA] = pend_nxt_s[RA];
      end
      inc_s = rsv_ok_s & ~pend_r[RA];
      dec_s = wr_ok_s & pend_r[WA] & ~(rsv_ok_s & (RA == WA));
      case ({inc_s, dec_s})
         2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
         2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Data storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_ok_s) begin
         regs_r[WA] <= WD;
      end
   end

   // Scoreboard state and its population counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_r <= {DEPTH{1'b0}};
         cnt_r  <= {(ADDR_W + 1){1'b0}};
      end else begin
         pend_r <= pend_nxt_s;
         cnt_r  <= cnt_nxt_s;
      end
   end

   assign PendCnt = cnt_r;

   // Combinational read ports with optional forwarding of the in-flight write.
   always_comb begin
      DR1   = regs_r[RR1];
      DR2   = regs_r[RR2];
      Busy1 = pend_r[RR1];
      Busy2 = pend_r[RR2];
`ifdef BANCO_REGISTROS_SB_BYPASS_EN
      if (wr_ok_s && (WA == RR1)) begin
         DR1   = WD;
         Busy1 = 1'b0;
      end else begin
         DR1   = regs_r[RR1];
      end
      if (wr_ok_s && (WA == RR2)) begin
         DR2   = WD;
         Busy2 = 1'b0;
      end else begin
         DR2   = regs_r[RR2];
      end
`else
      if (wr_ok_s) begin
         Busy1 = pend_r[RR1];
      end else begin
         Busy2 = pend_r[RR2];
      end
`endif
      if (HAS_ZERO && (RR1 == {ADDR_W{1'b0}})) begin
         DR1 = {DATA_W{1'b0}};
      end else begin
         DR1 = DR1;
      end
      if (HAS_ZERO && (RR2 == {ADDR_W{1'b0}})) begin
         DR2 = {DATA_W{1'b0}};
      end else begin
         DR2 = DR2;
      end
   end

endmodule

// File: tb/tb_banco_registros_sb.sv
// Self-checking bench for banco_registros_sb: vector table, directed corner sequences and random
// stimulus against a behavioural array model.
module tb_banco_registros_sb;

`ifdef BANCO_REGISTROS_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk, rst, Write, Reserve;
   logic [4:0]  WA, RR1, RR2, RA;
   logic [31:0] WD, DR1, DR2;
   logic        Busy1, Busy2;
   logic [5:0]  PendCnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_mem  [32];
   bit          m_pend [32];

   typedef struct {
      logic        w;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  rr1, rr2;
      logic        rsv;
      logic [4:0]  ra;
      logic [31:0] e_dr1, e_dr2;
      logic        e_b1, e_b2;
      logic [5:0]  e_cnt;
   } vec_t;

   vec_t tbl [9];

   banco_registros_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .Write(Write), .WA(WA), .WD(WD),
      .RR1(RR1), .RR2(RR2), .DR1(DR1), .DR2(DR2),
      .Reserve(Reserve), .RA(RA), .Busy1(Busy1), .Busy2(Busy2), .PendCnt(PendCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < 32; i++) c += m_pend[i];
      return c;
   endfunction

   function automatic logic [31:0] exp_dr(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (BYP && Write && (WA == a)) return WD;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (BYP && Write && (WA == a) && (a != 5'd0)) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = 32'd0;
         m_pend[i] = 1'b0;
      end
   endtask

   task automatic set_in(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] rr1, input logic [4:0] rr2,
                         input logic rsv, input logic [4:0] ra);
      Write = w; WA = wa; WD = wd; RR1 = rr1; RR2 = rr2; Reserve = rsv; RA = ra;
   endtask

   task automatic check_model();
      chk("model_DR1",     DR1,     exp_dr(RR1));
      chk("model_DR2",     DR2,     exp_dr(RR2));
      chk("model_Busy1",   {31'd0, Busy1}, {31'd0, exp_busy(RR1)});
      chk("model_Busy2",   {31'd0, Busy2}, {31'd0, exp_busy(RR2)});
      chk("model_PendCnt", {26'd0, PendCnt}, model_count());
   endtask

   // Clock edge: the model takes the write first, then the reserve, so a same-edge reserve wins.
   task automatic tick();
      @(posedge clk);
      if (Write && (WA != 5'd0)) begin
         m_mem[WA]  = WD;
         m_pend[WA] = 1'b0;
      end
      if (Reserve && (RA != 5'd0)) m_pend[RA] = 1'b1;
      #1;
   endtask

   initial begin
      //             w    wa     wd            rr1    rr2    rsv   ra     dr1           dr2           b1    b2    cnt
      tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0,        32'd0,        1'b0, 1'b0, 6'd0};
      tbl[1] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'd0,        1'b0, 1'b0, 6'd0};
      tbl[2] = '{1'b0, 5'd0, 32'd0,        5'd0, 5'd0, 1'b1, 5'd7, 32'd0,        32'd0,        1'b0, 1'b0, 6'd0};
      tbl[3] = '{1'b0, 5'd0, 32'd0,        5'd7, 5'd5, 1'b1, 5'd7, 32'd0,        32'hDEADBEEF, 1'b1, 1'b0, 6'd1};
      tbl[4] = '{1'b1, 5'd7, 32'd77,       5'd5, 5'd1, 1'b0, 5'd0, 32'hDEADBEEF, 32'd0,        1'b1, 1'b0, 6'd1};
      tbl[4].e_b1 = 1'b0;
      tbl[5] = '{1'b0, 5'd0, 32'd0,        5'd7, 5'd7, 1'b0, 5'd0, 32'd77,       32'd77,       1'b0, 1'b0, 6'd0};
      tbl[6] = '{1'b1, 5'd3, 32'd9,        5'd7, 5'd5, 1'b1, 5'd3, 32'd77,       32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
      tbl[7] = '{1'b0, 5'd0, 32'd0,        5'd3, 5'd0, 1'b1, 5'd0, 32'd9,        32'd0,        1'b1, 1'b0, 6'd1};
      tbl[8] = '{1'b0, 5'd0, 32'd0,        5'd3, 5'd0, 1'b0, 5'd0, 32'd9,        32'd0,        1'b1, 1'b0, 6'd1};

      // Reset held across edges with write and reserve requested: nothing may be taken.
      rst = 1'b1;
      set_in(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd6, 1'b1, 5'd6);
      #18;
      chk("rst_DR1",     DR1, 32'd0);
      chk("rst_DR2",     DR2, 32'd0);
      chk("rst_Busy1",   {31'd0, Busy1}, 32'd0);
      chk("rst_Busy2",   {31'd0, Busy2}, 32'd0);
      chk("rst_PendCnt", {26'd0, PendCnt}, 32'd0);
      set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
      #2 rst = 1'b0;
      model_reset();
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         set_in(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].rr1, tbl[i].rr2, tbl[i].rsv, tbl[i].ra);
         @(negedge clk);
         chk($sformatf("tbl%0d_DR1", i),  DR1, tbl[i].e_dr1);
         chk($sformatf("tbl%0d_DR2", i),  DR2, tbl[i].e_dr2);
         chk($sformatf("tbl%0d_Busy1", i), {31'd0, Busy1}, {31'd0, tbl[i].e_b1});
         chk($sformatf("tbl%0d_Busy2", i), {31'd0, Busy2}, {31'd0, tbl[i].e_b2});
         chk($sformatf("tbl%0d_PendCnt", i), {26'd0, PendCnt}, {26'd0, tbl[i].e_cnt});
         tick();
      end

      // Forwarding corner: reg[4]=1 pending, then write 2 while reading it.
      set_in(1'b1, 5'd4, 32'd1, 5'd0, 5'd0, 1'b1, 5'd4);
      @(negedge clk); check_model(); tick();
      set_in(1'b1, 5'd4, 32'd2, 5'd4, 5'd3, 1'b0, 5'd0);
      @(negedge clk);
      chk("byp_DR1",   DR1, BYP ? 32'd2 : 32'd1);
      chk("byp_Busy1", {31'd0, Busy1}, BYP ? 32'd0 : 32'd1);
      check_model(); tick();
      set_in(1'b0, 5'd0, 32'd0, 5'd4, 5'd3, 1'b0, 5'd0);
      @(negedge clk);
      chk("post_DR1",   DR1, 32'd2);
      chk("post_Busy1", {31'd0, Busy1}, 32'd0);
      tick();

      // Fill the scoreboard, then drain it; one extra write must not underflow.
      for (int a = 1; a < 32; a++) begin
         set_in(1'b0, 5'd0, 32'd0, 5'(a), 5'(a - 1), 1'b1, 5'(a));
         @(negedge clk); check_model(); tick();
      end
      @(negedge clk);
      chk("fill_PendCnt", {26'd0, PendCnt}, 32'd31);
      @(posedge clk); #1;
      for (int a = 1; a < 32; a++) begin
         set_in(1'b1, 5'(a), 32'(a * 3), 5'(a), 5'(32 - a), 1'b0, 5'd0);
         @(negedge clk); check_model(); tick();
      end
      set_in(1'b1, 5'd1, 32'hA5A5A5A5, 5'd1, 5'd2, 1'b0, 5'd0);
      @(negedge clk); check_model(); tick();
      set_in(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, 5'd0);
      @(negedge clk);
      chk("drain_PendCnt", {26'd0, PendCnt}, 32'd0);
      tick();

      // Random traffic with forced collisions and an asynchronous reset pulse midway.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] wa, rr1, rr2, ra;
         wa  = 5'($urandom_range(31));
         rr1 = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
         rr2 = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
         ra  = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
         if ($urandom_range(7) == 0) wa = 5'd0;
         set_in(1'($urandom_range(1)), wa, $urandom, rr1, rr2, 1'($urandom_range(1)), ra);
         @(negedge clk); check_model(); tick();
         if (n == 200) begin
            set_in(1'b0, 5'd0, 32'd0, 5'($urandom_range(31)), 5'($urandom_range(31)), 1'b0, 5'd0);
            @(negedge clk); #1;
            rst = 1'b1;
            #1;
            chk("async_rst_DR1",     DR1, 32'd0);
            chk("async_rst_DR2",     DR2, 32'd0);
            chk("async_rst_Busy1",   {31'd0, Busy1}, 32'd0);
            chk("async_rst_Busy2",   {31'd0, Busy2}, 32'd0);
            chk("async_rst_PendCnt", {26'd0, PendCnt}, 32'd0);
            #1 rst = 1'b0;
            model_reset();
            @(posedge clk); #1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
